// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line toward the receiver and received word / status back out.
`timescale 1ns/1ps
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  // master drives the line and consumes the received word; slave is the receiver
  modport master (output rx, input rx_data, rx_done, parity_err, frame_err, busy);
  modport slave  (input rx, output rx_data, rx_done, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable width, parity and stop bits.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_cfg_if.slave bus
);

  localparam int unsigned DIV    = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [SCNT_W-1:0] SC_HALF     = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SC_LAST     = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] B_DATA_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] B_STOP_LAST = BCNT_W'(STOP_BITS - 1);
  localparam logic              PAR_EN      = (PARITY != 0);
  localparam logic              PAR_ODD     = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_m, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [SCNT_W-1:0]    scnt;
  logic [BCNT_W-1:0]    bcnt;
  logic [DATA_BITS-1:0] sreg;
  logic                 par_pend, frm_pend, done_pend;
  logic                 tick_c, chg_c;
  logic                 shift_c, par_smp_c, stop_smp_c, last_stop_c, finish_c;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q, parity_err_q, frame_err_q, busy_q;

  assign tick_c = (state_q != S_IDLE) && (div_cnt == DIV_LAST);
  assign chg_c  = (state_d != state_q);

  // Two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle sampling strobes
  always_comb begin
    state_d     = state_q;
    shift_c     = 1'b0;
    par_smp_c   = 1'b0;
    stop_smp_c  = 1'b0;
    last_stop_c = 1'b0;
    finish_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (tick_c && (scnt == SC_HALF)) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick_c && (scnt == SC_LAST)) begin
          shift_c = 1'b1;
          if (bcnt == B_DATA_LAST) state_d = PAR_EN ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (tick_c && (scnt == SC_LAST)) begin
          par_smp_c = 1'b1;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (done_pend) begin
          finish_c = 1'b1;
          state_d  = S_IDLE;
        end else if (tick_c && (scnt == SC_LAST)) begin
          stop_smp_c  = 1'b1;
          last_stop_c = (bcnt == B_STOP_LAST);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Baud tick divider, parked at zero while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    div_cnt <= '0;
    else if (state_q == S_IDLE) div_cnt <= '0;
    else if (tick_c)            div_cnt <= '0;
    else                        div_cnt <= div_cnt + DIV_W'(1);
  end

  // Sample counter within a bit, restarted on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         scnt <= '0;
    else if (chg_c)  scnt <= '0;
    else if (tick_c) scnt <= (scnt == SC_LAST) ? '0 : scnt + SCNT_W'(1);
  end

  // Bit counter for data bits and stop bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          bcnt <= '0;
    else if (chg_c)                   bcnt <= '0;
    else if (shift_c || stop_smp_c)   bcnt <= bcnt + BCNT_W'(1);
  end

  // Shift register and pending status for the frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      par_pend  <= 1'b0;
      frm_pend  <= 1'b0;
      done_pend <= 1'b0;
    end else if (state_q == S_IDLE) begin
      par_pend  <= 1'b0;
      frm_pend  <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      if (shift_c)               sreg      <= {rx_s, sreg[DATA_BITS-1:1]};
      if (par_smp_c)             par_pend  <= (^{sreg, rx_s}) ^ PAR_ODD;
      if (stop_smp_c && !rx_s)   frm_pend  <= 1'b1;
      if (last_stop_c)           done_pend <= 1'b1;
    end
  end

  // Registered outputs; word and flags update together with the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_done_q <= finish_c;
      busy_q    <= (state_d != S_IDLE);
      if (finish_c) begin
        rx_data_q    <= sreg;
        parity_err_q <= par_pend;
        frame_err_q  <= frm_pend;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: drives 8N1, 8E1 and 7O2 receivers and checks every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 625_000;
  localparam int          BIT_NS   = 1600;
  localparam int          DIV      = 10;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_c ();

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // uniform views of the three receivers
  logic [8:0] o_data [3];
  logic       o_done [3];
  logic       o_pe   [3];
  logic       o_fe   [3];
  logic       o_busy [3];

  assign o_data[0] = 9'(if_a.rx_data);
  assign o_data[1] = 9'(if_b.rx_data);
  assign o_data[2] = 9'(if_c.rx_data);
  assign o_done[0] = if_a.rx_done;
  assign o_done[1] = if_b.rx_done;
  assign o_done[2] = if_c.rx_done;
  assign o_pe[0]   = if_a.parity_err;
  assign o_pe[1]   = if_b.parity_err;
  assign o_pe[2]   = if_c.parity_err;
  assign o_fe[0]   = if_a.frame_err;
  assign o_fe[1]   = if_b.frame_err;
  assign o_fe[2]   = if_c.frame_err;
  assign o_busy[0] = if_a.busy;
  assign o_busy[1] = if_b.busy;
  assign o_busy[2] = if_c.busy;

  // model: queued expectations {frame_err, parity_err, data} and the last delivered word
  logic [10:0] exp_q   [3][$];
  logic [10:0] last_v  [3];
  logic        prev_done [3];
  int          done_cnt  [3];
  int          done_cyc  [3];
  int          start_cyc [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s[%0d] actual=0x%0h required=0x%0h at %0t", name, idx, act, req, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        last_v[i]    = '0;
        prev_done[i] = 1'b0;
        exp_q[i].delete();
      end else begin
        if (o_done[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_done", i, 32'd1, 32'd0);
          end else begin
            last_v[i] = exp_q[i].pop_front();
            chk("word", i, {21'd0, o_fe[i], o_pe[i], o_data[i]}, {21'd0, last_v[i]});
          end
          chk("busy_at_done", i, 32'(o_busy[i]), 32'd0);
          chk("done_width", i, 32'(prev_done[i]), 32'd0);
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end else begin
          chk("hold", i, {21'd0, o_fe[i], o_pe[i], o_data[i]}, {21'd0, last_v[i]});
        end
        prev_done[i] = o_done[i];
      end
    end
  end

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       if_a.rx = v;
      1:       if_b.rx = v;
      default: if_c.rx = v;
    endcase
  endtask

  // send one frame; the model's expectation comes from the bits actually put on the line
  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input int pmode,
                            input logic pbit, input int nstop, input logic stop_val, input bit push);
    logic [8:0] m;
    logic       xr, pe;
    m = '0;
    for (int i = 0; i < nbits; i++) m[i] = d[i];
    xr = ^m;
    pe = (pmode == 0) ? 1'b0 : (pmode == 1) ? (xr ^ pbit) : ~(xr ^ pbit);
    if (push) exp_q[sel].push_back({~stop_val, pe, m});
    start_cyc[sel] = cyc;
    set_rx(sel, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < nbits; i++) begin
      set_rx(sel, d[i]);
      #(BIT_NS);
    end
    if (pmode != 0) begin
      set_rx(sel, pbit);
      #(BIT_NS);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(sel, stop_val);
      #(BIT_NS);
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic wait_done(input int sel, input int target, input string name);
    int k;
    k = 0;
    while (done_cnt[sel] < target && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk(name, sel, 32'(done_cnt[sel]), 32'(target));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    for (int i = 0; i < 3; i++) begin
      last_v[i]    = '0;
      prev_done[i] = 1'b0;
      done_cnt[i]  = 0;
      done_cyc[i]  = 0;
      start_cyc[i] = 0;
    end
    rst     = 1'b1;
    if_a.rx = 1'b1;
    if_b.rx = 1'b1;
    if_c.rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data", 0, 32'(o_data[0]), 32'd0);
    chk("rst_done", 0, 32'(o_done[0]), 32'd0);
    chk("rst_pe",   0, 32'(o_pe[0]),   32'd0);
    chk("rst_fe",   0, 32'(o_fe[0]),   32'd0);
    chk("rst_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("rst_data", 2, 32'(o_data[2]), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // back-to-back 8N1
    n = done_cnt[0];
    send_frame(0, 9'h030, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 9'h031, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 9'h032, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 9'h033, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_done(0, n + 4, "b2b_count");
    chk("b2b_last_data", 0, 32'(o_data[0]), 32'h33);

    // framing error, then a good word clears the flag
    #(BIT_NS);
    n = done_cnt[0];
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0, 1'b1);
    #(3 * BIT_NS);
    wait_done(0, n + 1, "ferr_count");
    chk("ferr_data", 0, 32'(o_data[0]), 32'h5A);
    chk("ferr_flag", 0, 32'(o_fe[0]),   32'd1);
    send_frame(0, 9'h012, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_done(0, n + 2, "good_after_ferr");
    chk("ferr_cleared", 0, 32'(o_fe[0]), 32'd0);

    // glitch shorter than half a bit
    #(BIT_NS);
    n = done_cnt[0];
    if_a.rx = 1'b0;
    #300;
    if_a.rx = 1'b1;
    #200;
    chk("glitch_busy_hi", 0, 32'(o_busy[0]), 32'd1);
    #2000;
    chk("glitch_busy_lo", 0, 32'(o_busy[0]), 32'd0);
    chk("glitch_no_done", 0, 32'(done_cnt[0]), 32'(n));
    chk("glitch_data",    0, 32'(o_data[0]), 32'h12);

    // reset in the middle of 0xFF, then a clean 0x55
    fork
      send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b1, 1'b0);
      begin
        #(5 * BIT_NS + 100);
        chk("pre_rst_busy", 0, 32'(o_busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", 0, 32'(o_data[0]), 32'd0);
        chk("mid_rst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("mid_rst_done", 0, 32'(o_done[0]), 32'd0);
        #19;
        rst = 1'b0;
      end
    join
    #(BIT_NS);
    n = done_cnt[0];
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_done(0, n + 1, "post_rst_count");
    chk("post_rst_data", 0, 32'(o_data[0]), 32'h55);

    // even parity: correct then wrong parity bit
    n = done_cnt[1];
    send_frame(1, 9'h0A5, 8, 1, 1'b0, 1, 1'b1, 1'b1);
    wait_done(1, n + 1, "even_ok_count");
    chk("even_ok_pe", 1, 32'(o_pe[1]), 32'd0);
    send_frame(1, 9'h0A5, 8, 1, 1'b1, 1, 1'b1, 1'b1);
    wait_done(1, n + 2, "even_bad_count");
    chk("even_bad_pe",   1, 32'(o_pe[1]),   32'd1);
    chk("even_bad_data", 1, 32'(o_data[1]), 32'hA5);

    // 7O2 word with latency
    n = done_cnt[2];
    send_frame(2, 9'h041, 7, 2, 1'b1, 2, 1'b1, 1'b1);
    wait_done(2, n + 1, "7o2_count");
    chk("7o2_model", 2, 32'(last_v[2]), 32'h041);
    chk("7o2_data",  2, 32'(o_data[2]), 32'h41);
    chk("7o2_pe",    2, 32'(o_pe[2]),   32'd0);
    chk("7o2_fe",    2, 32'(o_fe[2]),   32'd0);
    lat = done_cyc[2] - start_cyc[2];
    chk("7o2_latency_window", 2, 32'(lat), 32'(lat));
    if (lat < (168 * DIV + 3 - DIV) || lat > (168 * DIV + 3 + DIV))
      chk("7o2_latency", 2, 32'(lat), 32'(168 * DIV + 3));

    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("queue_drained", i, 32'(exp_q[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8N1 receiver inside the UART FIFO loopback path. It supports configurable data width, parity mode, stop-bit count, baud rate and oversampling, and reports parity and framing errors alongside each received word. It sits between the `rx` pin and the RX FIFO write port: `rx_done` drives the FIFO push and `rx_data` drives the FIFO write data.

## Interface

Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line bit rate.
- `OVERSAMPLE`, default 16: sample ticks per bit. Must be even and ≥ 8.
- `DATA_BITS`, default 8: payload width, legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rx`, in, 1: serial line, asynchronous to `clk`, idle high.
- `rx_data`, out, DATA_BITS: last received word, LSB received first.
- `rx_done`, out, 1: one-cycle pulse when `rx_data` and the error flags update.
- `parity_err`, out, 1: parity mismatch on the last word. Always 0 when `PARITY`=0.
- `frame_err`, out, 1: at least one stop bit sampled low on the last word.
- `busy`, out, 1: high whenever the state machine is not in IDLE.

## Operation

- **Input synchroniser:** `rx` passes through a 2-flop synchroniser (both flops reset to 1) to produce `rx_s`. All decisions use `rx_s` only.
- **Tick divider:**
  - `DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, computed at elaboration. Defaults give 651.
  - The divider counter is held at 0 in IDLE and runs in every other state.
  - `tick` is a one-cycle pulse when the counter reaches `DIV-1`; the counter then wraps to 0.
- **Sample counter:** `scnt` (width `$clog2(OVERSAMPLE)`) counts ticks within a bit. It is cleared on every state change.
- **States:** IDLE, START, DATA, PAR, STOP.
  - **IDLE:** when `rx_s`==0, go to START.
  - **START:** on the tick where `scnt`==OVERSAMPLE/2-1, sample `rx_s`. If 0, go to DATA and clear `scnt`. If 1, treat it as a glitch and return to IDLE with no `rx_done`.
  - **DATA:** on the tick where `scnt`==OVERSAMPLE-1, sample `rx_s` into a shift register, shifting right so the first bit ends up in the LSB. A bit counter `bcnt` counts samples. After DATA_BITS samples, go to PAR if `PARITY`≠0, otherwise go to STOP.
  - **PAR:** sample one bit at `scnt`==OVERSAMPLE-1.
    - Even mode: error if XOR(data, parity bit) is 1.
    - Odd mode: error if XOR(data, parity bit) is 0.
    - Then go to STOP.
  - **STOP:** sample at `scnt`==OVERSAMPLE-1, once per stop bit. Any sample of 0 sets the pending frame error.
    - The cycle after the last stop sample: load `rx_data`, `parity_err` and `frame_err`, pulse `rx_done`, and go to IDLE.
    - Because this happens mid-stop-bit, a start edge arriving right after the stop bit is captured. Back-to-back frames need no idle gap.
- **Frame errors:** `rx_data` is still delivered and `rx_done` still pulses. Error flags are sticky until the next `rx_done`, which overwrites them.
- **Reset:** when `rst` asserts at any time, including mid-frame, it immediately forces:
  - state IDLE, all counters 0, shift register 0, synchroniser flops 1;
  - `rx_data`=0, `rx_done`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - A partial frame is discarded. After `rst` deasserts, a line held low is treated as a new start bit.

## Timing

- **Synchroniser latency:** 2 `clk` cycles from the `rx` edge to `rx_s`.
- **Start-to-done latency:** from the start-bit falling edge at the pin to `rx_done` is `(OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS + (PARITY≠0) + STOP_BITS))*DIV + 3` cycles, ±DIV.
  - Defaults (8N1): (8 + 16*9)*651 + 3 = 98,955 cycles, about 989.6 µs (9.5 bit times).
- **Sampling accuracy:** the sampling point lies within ±1/OVERSAMPLE bit of bit centre. Tolerated baud mismatch is at least ±2%.
- **`rx_done`:** exactly 1 cycle wide, with no backpressure. `rx_data` is stable from the `rx_done` cycle until the next `rx_done`.
- **`busy`:**
  - rises 1 cycle after `rx_s` falls;
  - falls in the same cycle as `rx_done`, or 1 cycle after a glitch rejection.

## Test plan

- **Back-to-back 8N1:** defaults; send 0x30, 0x31, 0x32, 0x33 back-to-back at 104,166 ns/bit → four `rx_done` pulses with `rx_data` 0x30..0x33 in order, `parity_err`=`frame_err`=0, no pulse lost.
- **Even parity:** `PARITY`=1; send 0xA5 with parity bit 0 → `rx_data`=0xA5, `parity_err`=0. Then send 0xA5 with parity bit 1 → `rx_data`=0xA5, `parity_err`=1 with `rx_done`.
- **Framing error:** defaults; send 0x5A with stop bit driven 0 → `rx_done` pulses, `rx_data`=0x5A, `frame_err`=1. Then send a good 0x12 → `frame_err` returns to 0.
- **Glitch rejection:** drive `rx` low for 3 µs, then high → no `rx_done`, `busy` pulses high then returns to 0, and `rx_data` keeps its prior value.
- **Reset mid-frame:** assert `rst` for 20 ns after the 4th data bit of 0xFF → all outputs 0 at once, no `rx_done`. A following 0x55 frame is received correctly.
- **7O2:** `DATA_BITS`=7, `PARITY`=2, `STOP_BITS`=2; send 0x41 with odd parity bit 1 and two stop bits → `rx_data`=0x41, no errors, latency (8 + 16*10)*651 + 3 cycles ±651.
